psum_writeback: RTL
===================

PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 s_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 s_rst  in  1  reset, synchronous, active-high.
REQ-003 code_valid  in  1  one-cycle strobe; latches conv_in_ch and conv_img_size.
REQ-004 conv_in_ch  in  16  input-channel passes per output channel (>=1).
REQ-005 conv_img_size  in  16  ifmap size; ofmap is (conv_img_size-2)^2 pixels, conv_img_size>=5.
REQ-006 psum_in_valid / psum_in_ready  in / out  1 / 1  array psum handshake; transfer when both high.
REQ-007 psum_in_data  in  `ERS_MAX_WIDTH*`TIME_STEPS  one ofmap pixel, signed lane per time step, lane t at bits [t*W +: W].
REQ-008 rmw_rd_req / rmw_rd_addr  out  1 / `PSUM_RAM_DEPTH  psum RAM read port; data returns exactly 2 cycles after req.
REQ-009 rmw_rd_data  in  `ERS_MAX_WIDTH*`TIME_STEPS  psum RAM read data.
REQ-010 write_1line_en / write_1line_addr / write_1line_data  out  1 / `PSUM_RAM_DEPTH / `ERS_MAX_WIDTH*`TIME_STEPS  psum RAM write port.
REQ-011 o_read_data_mode  out  1  high = accumulated ofmap ready for psum readback (callback's i_read_data_mode).
REQ-012 i_readback_done  in  1  one-cycle strobe from readback side (Array_out_done).

Function
REQ-013 States: IDLE, ACCUM, FLUSH, HANDOFF; code_valid in any state reloads config, clears counters, enters ACCUM next cycle.
REQ-014 psum_in_ready SHALL be high only in ACCUM.
REQ-015 Pixel counter pix_x/pix_y rasters 0..conv_img_size-3, x fastest; write address = pix_y*(conv_img_size-2)+pix_x, from base 0.
REQ-016 Pass counter ch_cnt 0..conv_in_ch-1, increments when last pixel (x=y=size-3) of a pass is accepted.
REQ-017 Pass 0: accepted pixel written directly, write_1line_en 1 cycle after acceptance, data unchanged.
REQ-018 Pass >=1: rmw_rd_req with pixel address in acceptance cycle; write 3 cycles after acceptance with data = rmw_rd_data + delayed psum_in_data, lane-wise.
REQ-019 Full throughput: one pixel per cycle in every pass; no hazard since ofmap >=9 pixels exceeds 3-stage pipeline.
REQ-020 Last pixel of last pass accepted -> FLUSH; FLUSH waits until pipeline write drained (<=3 cycles), then HANDOFF.
REQ-021 HANDOFF: o_read_data_mode=1, ready=0; i_readback_done -> ACCUM with ch_cnt, pix_x, pix_y cleared (next output channel).
REQ-022 i_readback_done outside HANDOFF SHALL be ignored.
REQ-023 conv_in_ch=1: every pass is pass 0; rmw_rd_req never asserted.
REQ-024 Lane add width `ERS_MAX_WIDTH, signed, no carry between lanes; overflow per REQ-029.
REQ-025 code_valid during ACCUM/FLUSH: in-flight pipeline writes are discarded (write_1line_en forced 0 that cycle and onward until new acceptance).

Reset
REQ-026 On s_rst: state IDLE; psum_in_ready, rmw_rd_req, write_1line_en, o_read_data_mode = 0; all addresses, counters, config = 0.
REQ-027 Reset mid-operation aborts pipeline; no write issued in the cycle after reset deasserts.
REQ-028 Only code_valid leaves IDLE.

Configuration
REQ-029 Macro PSUM_SAT_EN: defined -> each lane add saturates to [-2^(W-1), 2^(W-1)-1]; undefined -> two's-complement wrap.

Verification
REQ-030 size=5, in_ch=1, 9 pixels data=k -> 9 writes, addr 0..8, data k, no rmw_rd_req, o_read_data_mode high 1-4 cycles after last.
REQ-031 size=6, in_ch=3, every lane=1 each pass, valid held high -> 48 accepted cycles back-to-back, final RAM lanes all 3 at addr 0..15.
REQ-032 Lane max positive + 1 in pass 1 -> with PSUM_SAT_EN stays max; without wraps to min negative.
REQ-033 HANDOFF, i_readback_done pulse -> ready returns high next cycle, next pass writes addr 0 as pass 0.
REQ-034 s_rst asserted mid pass 1 at pixel 4 -> all outputs 0 next cycle, no further writes until code_valid.
REQ-035 Random psum_in_valid gaps, size=7, in_ch=2 -> RAM equals scoreboard lane sums, addresses 0..24.

Source files
------------

// File: rtl/psum_writeback.sv
// Partial-sum writeback: accumulates one ofmap pixel per cycle into the psum RAM over all input-channel passes.
// Optional feature: define PSUM_SAT_EN for saturating lane adds (default build wraps in two's complement).
`ifndef ERS_MAX_WIDTH
`define ERS_MAX_WIDTH 8
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif
`ifndef PSUM_RAM_DEPTH
`define PSUM_RAM_DEPTH 10
`endif

module psum_writeback (
  input  logic                                    s_clk,
  input  logic                                    s_rst,
  input  logic                                    code_valid,
  input  logic [15:0]                             conv_in_ch,
  input  logic [15:0]                             conv_img_size,
  input  logic                                    psum_in_valid,
  output logic                                    psum_in_ready,
  input  logic [`ERS_MAX_WIDTH*`TIME_STEPS-1:0]   psum_in_data,
  output logic                                    rmw_rd_req,
  output logic [`PSUM_RAM_DEPTH-1:0]              rmw_rd_addr,
  input  logic [`ERS_MAX_WIDTH*`TIME_STEPS-1:0]   rmw_rd_data,
  output logic                                    write_1line_en,
  output logic [`PSUM_RAM_DEPTH-1:0]              write_1line_addr,
  output logic [`ERS_MAX_WIDTH*`TIME_STEPS-1:0]   write_1line_data,
  output logic                                    o_read_data_mode,
  input  logic                                    i_readback_done
);
  localparam int W  = `ERS_MAX_WIDTH;
  localparam int TS = `TIME_STEPS;
  localparam int AW = `PSUM_RAM_DEPTH;
  localparam int DW = W * TS;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, HANDOFF = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [15:0]   in_ch_q, in_ch_d, size_q, size_d;
  logic [15:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d, ch_cnt_q, ch_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          v1_q, v2_q, wr_en_q;
  logic [AW-1:0] a1_q, a2_q, wr_addr_q;
  logic [DW-1:0] d1_q, d2_q, wr_data_q, sum_s;
  logic [15:0]   last_s;
  logic          accept_s, pass0_s;

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef PSUM_SAT_EN
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      lane_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      lane_add = s[W-1:0];
    end
`else
    lane_add = a + b;
`endif
  endfunction

  // Raster runs 0..size-3 on both axes; the address counter tracks y*(size-2)+x.
  assign last_s           = size_q - 16'd3;
  assign psum_in_ready    = (state_q == ACCUM) && !code_valid;
  assign accept_s         = psum_in_valid && psum_in_ready;
  assign pass0_s          = (ch_cnt_q == 16'd0);
  assign rmw_rd_req       = accept_s && !pass0_s;
  assign rmw_rd_addr      = addr_q;
  assign write_1line_en   = wr_en_q && !code_valid;
  assign write_1line_addr = wr_addr_q;
  assign write_1line_data = wr_data_q;
  assign o_read_data_mode = (state_q == HANDOFF);

  always_comb begin
    sum_s = {DW{1'b0}};
    for (int t = 0; t < TS; t++) begin
      sum_s[t*W +: W] = lane_add(rmw_rd_data[t*W +: W], d2_q[t*W +: W]);
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ch_d  = in_ch_q;
    size_d   = size_q;
    pix_x_d  = pix_x_q;
    pix_y_d  = pix_y_q;
    ch_cnt_d = ch_cnt_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: state_d = IDLE;
      ACCUM: begin
        if (accept_s) begin
          if (pix_x_q == last_s) begin
            pix_x_d = 16'd0;
            if (pix_y_q == last_s) begin
              pix_y_d = 16'd0;
              addr_d  = {AW{1'b0}};
              if (ch_cnt_q == in_ch_q - 16'd1) begin
                ch_cnt_d = 16'd0;
                state_d  = FLUSH;
              end else begin
                ch_cnt_d = ch_cnt_q + 16'd1;
              end
            end else begin
              pix_y_d = pix_y_q + 16'd1;
              addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
            end
          end else begin
            pix_x_d = pix_x_q + 16'd1;
            addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ACCUM;
        end
      end
      FLUSH: begin
        if (!v1_q && !v2_q) begin
          state_d = HANDOFF;
        end else begin
          state_d = FLUSH;
        end
      end
      HANDOFF: begin
        if (i_readback_done) begin
          state_d  = ACCUM;
          pix_x_d  = 16'd0;
          pix_y_d  = 16'd0;
          ch_cnt_d = 16'd0;
          addr_d   = {AW{1'b0}};
        end else begin
          state_d = HANDOFF;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new configuration wins over anything the current state decided.
    if (code_valid) begin
      in_ch_d  = conv_in_ch;
      size_d   = conv_img_size;
      pix_x_d  = 16'd0;
      pix_y_d  = 16'd0;
      ch_cnt_d = 16'd0;
      addr_d   = {AW{1'b0}};
      state_d  = ACCUM;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q  <= IDLE;
      in_ch_q  <= 16'd0;
      size_q   <= 16'd0;
      pix_x_q  <= 16'd0;
      pix_y_q  <= 16'd0;
      ch_cnt_q <= 16'd0;
      addr_q   <= {AW{1'b0}};
    end else begin
      state_q  <= state_d;
      in_ch_q  <= in_ch_d;
      size_q   <= size_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      ch_cnt_q <= ch_cnt_d;
      addr_q   <= addr_d;
    end
  end

  // Pass 0 writes one cycle after acceptance; later passes wait two cycles for RAM data, then add and write.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      a1_q      <= {AW{1'b0}};
      a2_q      <= {AW{1'b0}};
      d1_q      <= {DW{1'b0}};
      d2_q      <= {DW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {DW{1'b0}};
    end else if (code_valid) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      v1_q <= accept_s && !pass0_s;
      a1_q <= addr_q;
      d1_q <= psum_in_data;
      v2_q <= v1_q;
      a2_q <= a1_q;
      d2_q <= d1_q;
      if (accept_s && pass0_s) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= psum_in_data;
      end else if (v2_q) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= a2_q;
        wr_data_q <= sum_s;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end
endmodule
